// File: rtl/iq_pkg.sv
// Shared encodings and width helpers for the IQ classification pipeline.
package iq_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    GROUND  = 2'b01,
    EXCITED = 2'b10,
    LINE    = 2'b11
  } iq_state_t;

  // Channel index width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iq_classify_pipe_if.sv
// Sample/result stream bundle. Both streams use valid/ready: a beat transfers on a
// rising edge where valid && ready; the source holds data stable while valid && !ready.
interface iq_classify_pipe_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [CH_W-1:0]            in_ch;
  logic signed [DATA_W-1:0]   i_val;
  logic signed [DATA_W-1:0]   q_val;

  logic                       out_valid;
  logic                       out_ready;
  logic [CH_W-1:0]            out_ch;
  logic [1:0]                 out_state;
  logic signed [2*DATA_W+1:0] out_dot;

  modport slave (
    input  in_valid, in_ch, i_val, q_val, out_ready,
    output in_ready, out_valid, out_ch, out_state, out_dot
  );

  modport master (
    output in_valid, in_ch, i_val, q_val, out_ready,
    input  in_ready, out_valid, out_ch, out_state, out_dot
  );
endinterface

// File: rtl/iq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module iq_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iq_classify_pipe.sv
// Three-stage per-channel IQ line classifier (subtract, multiply, sum/classify).
// Optional per-channel tallies are built when IQ_CLASSIFY_COUNT_EN is defined.
module iq_classify_pipe
  import iq_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  localparam int CH_W  = ch_w(NCH)
) (
  input  logic                     clk100,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic signed [DATA_W-1:0] cfg_i_pt,
  input  logic signed [DATA_W-1:0] cfg_q_pt,
  input  logic signed [DATA_W-1:0] cfg_i_perp,
  input  logic signed [DATA_W-1:0] cfg_q_perp,
`ifdef IQ_CLASSIFY_COUNT_EN
  input  logic                     cnt_clear,
  input  logic [CH_W-1:0]          cnt_ch,
  output logic [CNT_W-1:0]         cnt_ground,
  output logic [CNT_W-1:0]         cnt_excited,
`endif
  iq_classify_pipe_if.slave        s
);

  localparam int DW1 = DATA_W + 1;
  localparam int PW  = 2 * DATA_W + 1;
  localparam int SW  = 2 * DATA_W + 2;

  if (NCH < 1 || NCH > 16 || CNT_W < 1 || DATA_W < 2) begin : g_param_check
    $error("iq_classify_pipe: parameter out of range");
  end

  logic signed [DATA_W-1:0] c_ipt   [NCH];
  logic signed [DATA_W-1:0] c_qpt   [NCH];
  logic signed [DATA_W-1:0] c_iperp [NCH];
  logic signed [DATA_W-1:0] c_qperp [NCH];

  logic            en;
  logic [CH_W-1:0] sel;

  logic                     v1, v2;
  logic [CH_W-1:0]          ch1, ch2;
  logic signed [DW1-1:0]    di1, dq1;
  logic signed [DATA_W-1:0] ip1, qp1;
  logic signed [PW-1:0]     pi2, pq2;
  logic signed [SW-1:0]     sum3;
  iq_state_t                st3;

  assign en         = !s.out_valid || s.out_ready;
  assign s.in_ready = en;
  // Out-of-range channels borrow channel 0 coefficients but keep their tag.
  assign sel        = (int'(s.in_ch) < NCH) ? s.in_ch : '0;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        c_ipt[k]   <= '0;
        c_qpt[k]   <= '0;
        c_iperp[k] <= '0;
        c_qperp[k] <= '0;
      end
    end else if (cfg_we && (int'(cfg_ch) < NCH)) begin
      c_ipt[cfg_ch]   <= cfg_i_pt;
      c_qpt[cfg_ch]   <= cfg_q_pt;
      c_iperp[cfg_ch] <= cfg_i_perp;
      c_qperp[cfg_ch] <= cfg_q_perp;
    end
  end

  assign sum3 = SW'(pi2) + SW'(pq2);

  always_comb begin
    st3 = LINE;
    if (sum3[SW-1]) begin
      st3 = GROUND;
    end else if (sum3 != '0) begin
      st3 = EXCITED;
    end
  end

  // Perpendicular coefficients ride in S1 so a concurrent write cannot split a sample.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      v1          <= 1'b0;
      ch1         <= '0;
      di1         <= '0;
      dq1         <= '0;
      ip1         <= '0;
      qp1         <= '0;
      v2          <= 1'b0;
      ch2         <= '0;
      pi2         <= '0;
      pq2         <= '0;
      s.out_valid <= 1'b0;
      s.out_ch    <= '0;
      s.out_state <= NONE;
      s.out_dot   <= '0;
    end else if (en) begin
      v1          <= s.in_valid;
      ch1         <= s.in_ch;
      di1         <= DW1'(s.i_val) - DW1'(c_ipt[sel]);
      dq1         <= DW1'(s.q_val) - DW1'(c_qpt[sel]);
      ip1         <= c_iperp[sel];
      qp1         <= c_qperp[sel];
      v2          <= v1;
      ch2         <= ch1;
      pi2         <= PW'(di1) * PW'(ip1);
      pq2         <= PW'(dq1) * PW'(qp1);
      s.out_valid <= v2;
      s.out_ch    <= ch2;
      s.out_state <= v2 ? st3 : NONE;
      s.out_dot   <= sum3;
    end
  end

`ifdef IQ_CLASSIFY_COUNT_EN
  logic             hs;
  logic [CNT_W-1:0] g_cnt [NCH];
  logic [CNT_W-1:0] e_cnt [NCH];

  assign hs = s.out_valid && s.out_ready;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic clr_k;
    logic hit_k;
    assign clr_k = cnt_clear && (int'(cnt_ch) == k);
    assign hit_k = hs && (int'(s.out_ch) == k);

    iq_sat_counter #(.W(CNT_W)) u_ground (
      .clk (clk100),
      .rst (rst),
      .clr (clr_k),
      .inc (hit_k && (s.out_state == GROUND)),
      .cnt (g_cnt[k])
    );

    iq_sat_counter #(.W(CNT_W)) u_excited (
      .clk (clk100),
      .rst (rst),
      .clr (clr_k),
      .inc (hit_k && (s.out_state == EXCITED)),
      .cnt (e_cnt[k])
    );
  end

  assign cnt_ground  = (int'(cnt_ch) < NCH) ? g_cnt[cnt_ch] : '0;
  assign cnt_excited = (int'(cnt_ch) < NCH) ? e_cnt[cnt_ch] : '0;
`endif

endmodule

// File: tb/tb_iq_classify_pipe.sv
// Scoreboard bench for iq_classify_pipe; tally tests build only with IQ_CLASSIFY_COUNT_EN.
module tb_iq_classify_pipe;
  import iq_pkg::*;

  localparam int NCH   = 3;
  localparam int DW    = 32;
  localparam int CH_W  = ch_w(NCH);
  localparam int EXP_W = CH_W + 2 + 66;
`ifdef IQ_CLASSIFY_COUNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [CH_W-1:0] cfg_ch = '0;
  logic signed [DW-1:0] cfg_i_pt = '0, cfg_q_pt = '0, cfg_i_perp = '0, cfg_q_perp = '0;
`ifdef IQ_CLASSIFY_COUNT_EN
  logic cnt_clear = 1'b0;
  logic [CH_W-1:0] cnt_ch = '0;
  logic [CNT_W-1:0] cnt_ground, cnt_excited;
`endif

  iq_classify_pipe_if #(.DATA_W(DW), .CH_W(CH_W)) s ();

  iq_classify_pipe #(.NCH(NCH), .DATA_W(DW), .CNT_W(CNT_W)) dut (
    .clk100     (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_i_pt   (cfg_i_pt),
    .cfg_q_pt   (cfg_q_pt),
    .cfg_i_perp (cfg_i_perp),
    .cfg_q_perp (cfg_q_perp),
`ifdef IQ_CLASSIFY_COUNT_EN
    .cnt_clear  (cnt_clear),
    .cnt_ch     (cnt_ch),
    .cnt_ground (cnt_ground),
    .cnt_excited(cnt_excited),
`endif
    .s          (s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rx_count = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic signed [DW-1:0] m_ipt [NCH];
  logic signed [DW-1:0] m_qpt [NCH];
  logic signed [DW-1:0] m_iperp [NCH];
  logic signed [DW-1:0] m_qperp [NCH];

  function automatic logic [EXP_W-1:0] model(input logic [CH_W-1:0] ch,
                                             input logic signed [DW-1:0] i, q);
    int idx;
    logic signed [65:0] di, dq, dot;
    logic [1:0] st;
    idx = (int'(ch) < NCH) ? int'(ch) : 0;
    di = i;
    dq = q;
    di = di - m_ipt[idx];
    dq = dq - m_qpt[idx];
    dot = di * m_iperp[idx] + dq * m_qperp[idx];
    st = (dot > 0) ? 2'b10 : ((dot < 0) ? 2'b01 : 2'b11);
    return {ch, st, dot};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) begin
      m_ipt[k] = '0; m_qpt[k] = '0; m_iperp[k] = '0; m_qperp[k] = '0;
    end
  endtask

  // Scoreboard: every output handshake pops and compares one expected result.
  always @(negedge clk) begin
    logic [EXP_W-1:0] got, exp_v;
    #2;
    if (!rst && s.out_valid && s.out_ready) begin
      got = {s.out_ch, s.out_state, s.out_dot};
      rx_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got=%h required=nothing", got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          bad++;
          $display("FAIL sb_result: got=%h required=%h", got, exp_v);
        end
      end
    end
  end

  task automatic send(input logic [CH_W-1:0] ch, input logic signed [DW-1:0] i, q);
    int guard = 0;
    @(negedge clk);
    s.in_valid = 1'b1; s.in_ch = ch; s.i_val = i; s.q_val = q;
    #1;
    while (!s.in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!s.in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%b required=1", s.in_ready);
    end else begin
      exp_q.push_back(model(ch, i, q));
    end
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    s.in_valid = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic signed [DW-1:0] ipt, qpt, ip, qp);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch;
    cfg_i_pt = ipt; cfg_q_pt = qpt; cfg_i_perp = ip; cfg_q_perp = qp;
    @(negedge clk);
    cfg_we = 1'b0;
    if (int'(ch) < NCH) begin
      m_ipt[ch] = ipt; m_qpt[ch] = qpt; m_iperp[ch] = ip; m_qperp[ch] = qp;
    end
  endtask

  task automatic wait_empty();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      #3;
      g++;
    end
  endtask

  task automatic test_reset();
    s.in_valid = 1'b0; s.in_ch = '0; s.i_val = '0; s.q_val = '0; s.out_ready = 1'b1;
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    total++; if (s.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%b required=0", s.out_valid); end
    total++; if (s.out_state !== 2'b00) begin bad++; $display("FAIL rst_state: got=%b required=00", s.out_state); end
    total++; if (s.out_dot !== '0) begin bad++; $display("FAIL rst_dot: got=%h required=0", s.out_dot); end
    total++; if (s.out_ch !== '0) begin bad++; $display("FAIL rst_ch: got=%h required=0", s.out_ch); end
`ifdef IQ_CLASSIFY_COUNT_EN
    total++; if (cnt_excited !== '0 || cnt_ground !== '0) begin
      bad++; $display("FAIL rst_cnt: got=%h/%h required=0/0", cnt_ground, cnt_excited);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    #2;
    total++; if (s.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got=%b required=1", s.in_ready); end
  endtask

  task automatic test_zero_coef();
    int rx0 = rx_count;
    for (int k = 0; k < 4; k++) send(CH_W'($urandom_range(0, 3)), $urandom, $urandom);
    go_idle();
    wait_empty();
    total++; if (rx_count - rx0 != 4) begin bad++; $display("FAIL zero_coef_count: got=%0d required=4", rx_count - rx0); end
  endtask

  task automatic test_basic();
    cfg_write(1, 0, 0, 1, 0);
    @(negedge clk);
    s.in_valid = 1'b1; s.in_ch = 1; s.i_val = 5; s.q_val = -7;
    #1;
    total++; if (s.in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got=%b required=1", s.in_ready); end
    exp_q.push_back(model(1, 5, -7));
    @(negedge clk);
    s.in_valid = 1'b0;
    #2;
    total++; if (s.out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat1: got=%b required=0", s.out_valid); end
    @(negedge clk); #2;
    total++; if (s.out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat2: got=%b required=0", s.out_valid); end
    @(negedge clk); #2;
    total++; if (s.out_valid !== 1'b1) begin bad++; $display("FAIL basic_lat3: got=%b required=1", s.out_valid); end
    total++; if (s.out_state !== 2'b10) begin bad++; $display("FAIL basic_state: got=%b required=10", s.out_state); end
    total++; if (s.out_dot !== 66'sd5) begin bad++; $display("FAIL basic_dot: got=%h required=5", s.out_dot); end
    total++; if (s.out_ch !== 2'd1) begin bad++; $display("FAIL basic_ch: got=%h required=1", s.out_ch); end
  endtask

  task automatic test_ground_line();
    send(1, -3, 100);
    send(1, 0, 42);
    go_idle();
    wait_empty();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL gl_drain: got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_cfg_coincident();
    cfg_write(1, 0, 0, 1, 0);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 1; cfg_i_pt = 0; cfg_q_pt = 0; cfg_i_perp = -1; cfg_q_perp = 0;
    s.in_valid = 1'b1; s.in_ch = 1; s.i_val = 9; s.q_val = 3;
    #1;
    total++; if (s.in_ready !== 1'b1) begin bad++; $display("FAIL coinc_ready: got=%b required=1", s.in_ready); end
    exp_q.push_back(model(1, 9, 3));
    @(posedge clk);
    m_iperp[1] = -1;
    go_idle();
    send(1, 9, 3);
    go_idle();
    wait_empty();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL coinc_drain: got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_extreme();
    int g = 0;
    cfg_write(0, 32'sh8000_0000, 32'sh8000_0000, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF);
    send(0, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF);
    go_idle();
    while (s.out_valid !== 1'b1 && g < 10) begin @(negedge clk); #2; g++; end
    total++; if (s.out_dot !== 66'sh0_FFFF_FFFD_0000_0002) begin
      bad++; $display("FAIL extreme_dot: got=%h required=0fffffffd00000002", s.out_dot);
    end
    total++; if (s.out_state !== 2'b10) begin bad++; $display("FAIL extreme_state: got=%b required=10", s.out_state); end
    send(3, 32'sh7FFF_FFFF, -5);
    go_idle();
    wait_empty();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL extreme_drain: got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int rx0 = rx_count;
    logic [EXP_W:0] held;
    fork
      begin
        for (int k = 0; k < 8; k++) send(CH_W'(k % 4), k * 7 - 20, k);
        go_idle();
      end
      begin
        repeat (5) @(negedge clk);
        s.out_ready = 1'b0;
        #2;
        held = {s.out_valid, s.out_ch, s.out_state, s.out_dot};
        total++; if (s.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got=%b required=1", s.out_valid); end
        total++; if (s.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready: got=%b required=0", s.in_ready); end
        repeat (3) begin
          @(negedge clk); #2;
          total++; if (s.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_hold: got=%b required=0", s.in_ready); end
          total++; if ({s.out_valid, s.out_ch, s.out_state, s.out_dot} !== held) begin
            bad++; $display("FAIL b2b_hold: got=%h required=%h", {s.out_valid, s.out_ch, s.out_state, s.out_dot}, held);
          end
        end
        @(negedge clk);
        s.out_ready = 1'b1;
      end
    join
    wait_empty();
    total++; if (rx_count - rx0 != 8) begin bad++; $display("FAIL b2b_count: got=%0d required=8", rx_count - rx0); end
  endtask

  task automatic test_random();
    int rx0 = rx_count;
    for (int c = 0; c < 4; c++) cfg_write(CH_W'(c), $urandom, $urandom, $urandom, $urandom);
    for (int c = 0; c < 3; c++) cfg_write(CH_W'(c), $urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100,
                                          $urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10);
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          if (k % 2 == 0) send(CH_W'($urandom_range(0, 3)), $urandom, $urandom);
          else send(CH_W'($urandom_range(0, 3)), $urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100);
        end
        go_idle();
      end
      begin
        repeat (60) begin
          @(negedge clk);
          s.out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        s.out_ready = 1'b1;
      end
    join
    wait_empty();
    total++; if (rx_count - rx0 != 40) begin bad++; $display("FAIL rand_count: got=%0d required=40", rx_count - rx0); end
  endtask

`ifdef IQ_CLASSIFY_COUNT_EN
  task automatic test_tally();
    int g = 0;
    cfg_write(2, 0, 0, 1, 0);
    @(negedge clk); cnt_clear = 1'b1; cnt_ch = 2;
    @(negedge clk); cnt_clear = 1'b0;
    for (int k = 0; k < 20; k++) send(2, 10, 0);
    go_idle();
    wait_empty();
    @(negedge clk); #2;
    total++; if (cnt_excited !== 4'd15) begin bad++; $display("FAIL tally_sat: got=%0d required=15", cnt_excited); end
    total++; if (cnt_ground !== 4'd0) begin bad++; $display("FAIL tally_g0: got=%0d required=0", cnt_ground); end
    send(2, -4, 0);
    send(2, 0, 9);
    go_idle();
    wait_empty();
    @(negedge clk); #2;
    total++; if (cnt_ground !== 4'd1) begin bad++; $display("FAIL tally_g1: got=%0d required=1", cnt_ground); end
    s.out_ready = 1'b0;
    send(2, 10, 0);
    go_idle();
    while (s.out_valid !== 1'b1 && g < 10) begin @(negedge clk); #2; g++; end
    @(negedge clk);
    cnt_clear = 1'b1; s.out_ready = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    #2;
    total++; if (cnt_excited !== 4'd0) begin bad++; $display("FAIL tally_clr: got=%0d required=0", cnt_excited); end
    wait_empty();
  endtask
`endif

  task automatic test_reset_inflight();
    cfg_write(1, 0, 0, 1, 0);
    send(1, 5, 0);
    send(1, 6, 0);
    @(negedge clk);
    rst = 1'b1; s.in_valid = 1'b0;
    exp_q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk); #2;
      total++; if (s.out_valid !== 1'b0) begin bad++; $display("FAIL inflight_valid: got=%b required=0", s.out_valid); end
    end
`ifdef IQ_CLASSIFY_COUNT_EN
    cnt_ch = 1;
    #1;
    total++; if (cnt_excited !== '0 || cnt_ground !== '0) begin
      bad++; $display("FAIL inflight_cnt: got=%0d/%0d required=0/0", cnt_ground, cnt_excited);
    end
`endif
    send(0, 1234, -77);
    send(1, -9, 5);
    go_idle();
    wait_empty();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL inflight_drain: got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_zero_coef();
    test_basic();
    test_ground_line();
    test_cfg_coincident();
    test_extreme();
    test_back_to_back();
    test_random();
`ifdef IQ_CLASSIFY_COUNT_EN
    test_tally();
`endif
    test_reset_inflight();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
